// File: rtl/blink_sched.sv
// ---------------------------------------------------------------------------
// blink_sched
// Sequences a four-digit enable pattern for the 7-segment decoders, advancing
// one pattern step every STEP_TICKS timebase strobes. Four patterns are
// available: blink-all, chase-left, chase-right and solid. A pause level
// freezes the sequence and stop returns the block to an idle, blanked state.
//
// Ports
//   CLK       in   1  system clock, all state changes on the rising edge
//   RST       in   1  synchronous active-high reset
//   tick      in   1  one-cycle timebase strobe
//   start     in   1  one-cycle request to begin sequencing (IDLE only)
//   stop      in   1  one-cycle request to end sequencing (any state)
//   pause     in   1  level, holds the sequence while high
//   mode      in   2  00 blink-all, 01 chase-left, 10 chase-right, 11 solid
//   dig_en    out  4  per-digit enable, bit0 = digit 0
//   gpio      out  1  LED drive, high whenever any digit is enabled
//   busy      out  1  high while sequencing or held
//   step_cnt  out  8  steps completed since the last start, wraps at 256
// ---------------------------------------------------------------------------
module blink_sched #(
    parameter int STEP_TICKS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [3:0] dig_en,
    output logic       gpio,
    output logic       busy,
    output logic [7:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_TICK = 4'(STEP_TICKS - 1);

    state_t     r_state;
    logic [1:0] r_activeMode;
    logic [3:0] r_tickCnt;
    logic [3:0] r_pattern;
    logic [7:0] r_stepCnt;
    logic       r_gpio;
    logic       r_busy;

    logic       w_modeChange;
    logic [3:0] w_initPattern;
    logic [3:0] w_nextPattern;

    // First pattern shown when a mode becomes active.
    function automatic logic [3:0] initPattern(input logic [1:0] m);
        case (m)
            2'b00:   initPattern = 4'b1111;
            2'b01:   initPattern = 4'b0001;
            2'b10:   initPattern = 4'b1000;
            default: initPattern = 4'b1111;
        endcase
    endfunction

    // Pattern after one step of an unchanged mode.
    function automatic logic [3:0] stepPattern(input logic [1:0] m,
                                               input logic [3:0] p);
        case (m)
            2'b00:   stepPattern = ~p;
            2'b01:   stepPattern = {p[2:0], p[3]};
            2'b10:   stepPattern = {p[0], p[3:1]};
            default: stepPattern = p;
        endcase
    endfunction

    // A mode change seen at a step reloads the new mode's first pattern
    // rather than advancing the old one.
    assign w_modeChange  = (mode != r_activeMode);
    assign w_initPattern = initPattern(mode);
    assign w_nextPattern = w_modeChange ? w_initPattern
                                        : stepPattern(r_activeMode, r_pattern);

    // Single state machine; gpio is computed from the value being loaded into
    // the pattern register so that it moves on the same edge as dig_en.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_activeMode <= 2'b00;
            r_tickCnt    <= 4'd0;
            r_pattern    <= 4'd0;
            r_stepCnt    <= 8'd0;
            r_gpio       <= 1'b0;
            r_busy       <= 1'b0;
        end else if (stop) begin
            r_state   <= IDLE;
            r_pattern <= 4'd0;
            r_gpio    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= RUN;
                        r_activeMode <= mode;
                        r_tickCnt    <= 4'd0;
                        r_stepCnt    <= 8'd0;
                        r_pattern    <= w_initPattern;
                        r_gpio       <= |w_initPattern;
                        r_busy       <= 1'b1;
                    end
                end
                RUN: begin
                    // A tick arriving with pause high is dropped.
                    if (pause) begin
                        r_state <= HOLD;
                    end else if (tick) begin
                        if (r_tickCnt == LAST_TICK) begin
                            r_tickCnt    <= 4'd0;
                            r_activeMode <= mode;
                            r_pattern    <= w_nextPattern;
                            r_gpio       <= |w_nextPattern;
                            r_stepCnt    <= r_stepCnt + 8'd1;
                        end else begin
                            r_tickCnt <= r_tickCnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pattern <= 4'd0;
                    r_gpio    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dig_en   = r_pattern;
    assign gpio     = r_gpio;
    assign busy     = r_busy;
    assign step_cnt = r_stepCnt;

endmodule

// File: tb/tb_blink_sched.sv
// ---------------------------------------------------------------------------
// tb_blink_sched
// Drives two blink_sched instances (STEP_TICKS = 1 and 3) from the same
// inputs and compares both against a behavioural model that tracks the
// display as a chase position or blink phase rather than a bit pattern.
// ---------------------------------------------------------------------------
module tb_blink_sched;

   logic       CLK = 1'b0;
   logic       RST;
   logic       tick;
   logic       start;
   logic       stop;
   logic       pause;
   logic [1:0] mode;

   logic [3:0] digA, digB;
   logic       gpioA, gpioB, busyA, busyB;
   logic [7:0] stepA, stepB;

   int testCount = 0;
   int failCount = 0;

   // Model state per instance: index 0 is STEP_TICKS=1, index 1 is STEP_TICKS=3
   int stepTicksOf[2] = '{1, 3};
   int mRunning[2];
   int mHeld[2];
   int mMode[2];
   int mPos[2];
   int mPhase[2];
   int mTicks[2];
   int mSteps[2];

   blink_sched #(.STEP_TICKS(1)) dutA (
      .CLK(CLK), .RST(RST), .tick(tick), .start(start), .stop(stop),
      .pause(pause), .mode(mode), .dig_en(digA), .gpio(gpioA),
      .busy(busyA), .step_cnt(stepA)
   );

   blink_sched #(.STEP_TICKS(3)) dutB (
      .CLK(CLK), .RST(RST), .tick(tick), .start(start), .stop(stop),
      .pause(pause), .mode(mode), .dig_en(digB), .gpio(gpioB),
      .busy(busyB), .step_cnt(stepB)
   );

   // Free-running clock, 10 time units per period
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Display the model expects: chase modes as a lit position, blink as a phase
   function automatic int modelDigits(input int k);
      if (!mRunning[k]) return 0;
      case (mMode[k])
         0:       return (mPhase[k] != 0) ? 15 : 0;
         1, 2:    return 1 << mPos[k];
         default: return 15;
      endcase
   endfunction

   task automatic modelFreshMode(input int k, input int m);
      mMode[k]  = m;
      mPos[k]   = (m == 2) ? 3 : 0;
      mPhase[k] = 1;
   endtask

   task automatic modelAdvance(input int k);
      case (mMode[k])
         0:       mPhase[k] = 1 - mPhase[k];
         1:       mPos[k] = (mPos[k] + 1) % 4;
         2:       mPos[k] = (mPos[k] + 3) % 4;
         default: ;
      endcase
   endtask

   // Apply one clock's worth of the behavioural rules using the current inputs
   task automatic modelClock(input int k);
      if (RST) begin
         mRunning[k] = 0; mHeld[k] = 0; mTicks[k] = 0; mSteps[k] = 0;
         modelFreshMode(k, 0);
      end else if (stop) begin
         mRunning[k] = 0; mHeld[k] = 0;
      end else if (!mRunning[k]) begin
         if (start) begin
            mRunning[k] = 1; mHeld[k] = 0; mTicks[k] = 0; mSteps[k] = 0;
            modelFreshMode(k, int'(mode));
         end
      end else if (mHeld[k] != 0) begin
         if (!pause) mHeld[k] = 0;
      end else if (pause) begin
         mHeld[k] = 1;
      end else if (tick) begin
         mTicks[k]++;
         if (mTicks[k] == stepTicksOf[k]) begin
            mTicks[k] = 0;
            mSteps[k] = (mSteps[k] + 1) % 256;
            if (int'(mode) != mMode[k]) modelFreshMode(k, int'(mode));
            else modelAdvance(k);
         end
      end
   endtask

   // Drive one cycle of inputs, clock it, and compare both instances
   task automatic applyStimulus(input logic r, input logic t, input logic sa,
                                input logic so, input logic p,
                                input logic [1:0] m);
      int eA, eB;
      RST = r; tick = t; start = sa; stop = so; pause = p; mode = m;
      modelClock(0);
      modelClock(1);
      @(posedge CLK);
      #1;
      eA = modelDigits(0);
      eB = modelDigits(1);
      checkOutput("A.dig_en", 32'(digA), 32'(eA));
      checkOutput("A.gpio", 32'(gpioA), (eA != 0) ? 32'd1 : 32'd0);
      checkOutput("A.busy", 32'(busyA), 32'(mRunning[0]));
      checkOutput("A.step_cnt", 32'(stepA), 32'(mSteps[0]));
      checkOutput("B.dig_en", 32'(digB), 32'(eB));
      checkOutput("B.gpio", 32'(gpioB), (eB != 0) ? 32'd1 : 32'd0);
      checkOutput("B.busy", 32'(busyB), 32'(mRunning[1]));
      checkOutput("B.step_cnt", 32'(stepB), 32'(mSteps[1]));
   endtask

   initial begin
      logic [3:0] chaseSeq [5];
      logic       rndPause;
      logic [1:0] rndMode;

      chaseSeq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      for (int k = 0; k < 2; k++) begin
         mRunning[k] = 0; mHeld[k] = 0; mTicks[k] = 0; mSteps[k] = 0;
         modelFreshMode(k, 0);
      end
      RST = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      mode = 2'b00;
      @(negedge CLK);

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 2'b00);
      applyStimulus(1, 1, 1, 0, 1, 2'b11);
      checkOutput("reset.dig_en", 32'(digA), 32'd0);
      checkOutput("reset.step_cnt", 32'(stepB), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);

      // Chase-left, five ticks at one tick per step
      applyStimulus(0, 1, 1, 0, 0, 2'b01);
      checkOutput("chase.init", 32'(digA), 32'h1);
      checkOutput("chase.gpio", 32'(gpioA), 32'h1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 2'b01);
         checkOutput("chase.step", 32'(digA), 32'(chaseSeq[i]));
         applyStimulus(0, 0, 0, 0, 0, 2'b01);
      end
      checkOutput("chase.count", 32'(stepA), 32'd5);

      // Blink-all at three ticks per step
      applyStimulus(0, 0, 0, 1, 0, 2'b00);
      applyStimulus(0, 0, 1, 0, 0, 2'b00);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 2'b00);
         checkOutput("blink.dig_en", 32'(digB),
                     (i >= 3 && i < 6) ? 32'h0 : 32'hF);
         checkOutput("blink.gpio", 32'(gpioB),
                     (i >= 3 && i < 6) ? 32'h0 : 32'h1);
      end
      checkOutput("blink.count", 32'(stepB), 32'd2);

      // Mode change between steps reloads the new pattern
      applyStimulus(0, 0, 0, 1, 0, 2'b10);
      applyStimulus(0, 0, 1, 0, 0, 2'b10);
      checkOutput("right.init", 32'(digA), 32'h8);
      applyStimulus(0, 1, 0, 0, 0, 2'b10);
      checkOutput("right.step", 32'(digA), 32'h4);
      applyStimulus(0, 0, 0, 0, 0, 2'b01);
      checkOutput("reload.before", 32'(digA), 32'h4);
      applyStimulus(0, 1, 0, 0, 0, 2'b01);
      checkOutput("reload.dig_en", 32'(digA), 32'h1);
      checkOutput("reload.count", 32'(stepA), 32'd2);

      // Pause with a coincident tick, ticks while held, then release
      applyStimulus(0, 1, 0, 0, 1, 2'b01);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0, 1, 2'b01);
         checkOutput("hold.dig_en", 32'(digA), 32'h1);
         checkOutput("hold.busy", 32'(busyA), 32'h1);
      end
      applyStimulus(0, 0, 0, 0, 0, 2'b01);
      applyStimulus(0, 1, 0, 0, 0, 2'b01);
      checkOutput("release.dig_en", 32'(digA), 32'h2);
      checkOutput("release.count", 32'(stepA), 32'd3);

      // Stop beats start
      applyStimulus(0, 1, 1, 1, 0, 2'b01);
      checkOutput("stop.dig_en", 32'(digA), 32'h0);
      checkOutput("stop.busy", 32'(busyA), 32'h0);
      checkOutput("stop.count", 32'(stepA), 32'd3);

      // Reset in the middle of a run
      applyStimulus(0, 0, 1, 0, 0, 2'b00);
      applyStimulus(0, 1, 0, 0, 0, 2'b00);
      applyStimulus(1, 1, 0, 0, 0, 2'b00);
      checkOutput("midrst.busy", 32'(busyA), 32'h0);
      checkOutput("midrst.gpio", 32'(gpioA), 32'h0);

      // Step counter wraps after 256 steps
      applyStimulus(0, 0, 1, 0, 0, 2'b11);
      for (int i = 0; i < 255; i++) applyStimulus(0, 1, 0, 0, 0, 2'b11);
      checkOutput("wrap.255", 32'(stepA), 32'd255);
      applyStimulus(0, 1, 0, 0, 0, 2'b11);
      checkOutput("wrap.0", 32'(stepA), 32'd0);
      checkOutput("wrap.busy", 32'(busyA), 32'h1);

      // Randomized traffic
      rndPause = 1'b0;
      rndMode  = 2'b00;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(14, 0) == 0) rndPause = ~rndPause;
         if ($urandom_range(19, 0) == 0) rndMode = 2'($urandom_range(3, 0));
         applyStimulus(($urandom_range(199, 0) == 0),
                       ($urandom_range(2, 0) == 0),
                       ($urandom_range(9, 0) == 0),
                       ($urandom_range(39, 0) == 0),
                       rndPause, rndMode);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
